candy_vend_ctrl: RTL and testbench

Vending-machine control FSM that accepts coin pulses, accumulates credit, and runs dispense and refund sequences. It produces the credit total `sum[3:0]` and dispensed-candy count `candy_sum[2:0]`. These feed the seven-segment display stage directly downstream. All outputs are registered.

---
 rtl/candy_vend_ctrl.sv | 164 ++++++++++++++++
 tb/tb_candy_vend_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/candy_vend_ctrl.sv
// -----------------------------------------------------------------------------
// candy_vend_ctrl
// Vending-machine control FSM. Accumulates credit from coin pulses, runs a
// timed dispense sequence per vend and a one-unit-per-cycle refund sequence.
// All outputs are registered so the downstream seven-segment stage sees
// values that only move on the documented edges.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   coin1/2/5    single-cycle coin pulses (+1/+2/+5 credit units)
//   vend_req     single-cycle request for one candy
//   refund_req   single-cycle request to return all credit
//   sum          current credit (0..15)
//   candy_sum    candies dispensed since reset (saturates at MAX_CANDY)
//   dispense     motor drive, high for DISPENSE_CYCLES cycles per vend
//   change_pulse one pulse per credit unit returned
//   coin_reject  1-cycle pulse when an asserted coin was not accepted
//   vend_denied  1-cycle pulse when vend_req was refused
//   busy         high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module candy_vend_ctrl #(
  parameter int PRICE           = 3,
  parameter int DISPENSE_CYCLES = 4,
  parameter int MAX_CANDY       = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin1,
  input  logic       coin2,
  input  logic       coin5,
  input  logic       vend_req,
  input  logic       refund_req,
  output logic [3:0] sum,
  output logic [2:0] candy_sum,
  output logic       dispense,
  output logic       change_pulse,
  output logic       coin_reject,
  output logic       vend_denied,
  output logic       busy
);

  localparam int CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DISPENSE_CYCLES - 1);
  localparam logic [3:0] PRICE_U = 4'(PRICE);
  localparam logic [2:0] MAX_U   = 3'(MAX_CANDY);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    REFUND   = 2'd2
  } state_t;

  state_t           state_reg;
  logic [3:0]       sum_reg;
  logic [2:0]       candy_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             dispense_reg;
  logic             change_reg;
  logic             reject_reg;
  logic             denied_reg;
  logic             busy_reg;

  // Highest-priority coin this cycle and how many coin lines are asserted.
  logic [3:0] coin_val;
  logic [1:0] coin_cnt;
  logic       coin_fits;
  logic       any_coin;

  always_comb begin
    coin_val = 4'd0;
    if (coin5)      coin_val = 4'd5;
    else if (coin2) coin_val = 4'd2;
    else if (coin1) coin_val = 4'd1;
    coin_cnt = {1'b0, coin1} + {1'b0, coin2} + {1'b0, coin5};
    // Sum in 5 bits so a coin that would push credit past 15 is refused
    // instead of wrapping.
    coin_fits = ({1'b0, sum_reg} + {1'b0, coin_val}) <= 5'd15;
    any_coin  = coin1 | coin2 | coin5;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      sum_reg      <= 4'd0;
      candy_reg    <= 3'd0;
      cnt_reg      <= '0;
      dispense_reg <= 1'b0;
      change_reg   <= 1'b0;
      reject_reg   <= 1'b0;
      denied_reg   <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      // Pulse outputs default low; any asserted coin is rejected unless the
      // IDLE coin path below accepts it.
      reject_reg <= any_coin;
      denied_reg <= 1'b0;
      change_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (refund_req) begin
            if (sum_reg != 4'd0) begin
              state_reg  <= REFUND;
              change_reg <= 1'b1;
              busy_reg   <= 1'b1;
            end
          end else if (vend_req) begin
            if (sum_reg >= PRICE_U && candy_reg < MAX_U) begin
              state_reg    <= DISPENSE;
              dispense_reg <= 1'b1;
              cnt_reg      <= '0;
              busy_reg     <= 1'b1;
            end else begin
              denied_reg <= 1'b1;
            end
          end else if (coin_cnt != 2'd0 && coin_fits) begin
            sum_reg    <= sum_reg + coin_val;
            // Lower-priority coins in the same cycle are dropped.
            reject_reg <= (coin_cnt > 2'd1);
          end
        end

        DISPENSE: begin
          if (cnt_reg == CNT_LAST) begin
            sum_reg      <= sum_reg - PRICE_U;
            candy_reg    <= candy_reg + 3'd1;
            state_reg    <= IDLE;
            dispense_reg <= 1'b0;
            busy_reg     <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        REFUND: begin
          // The pulse for the final unit is the cycle where sum reads 1.
          sum_reg <= sum_reg - 4'd1;
          if (sum_reg == 4'd1) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            change_reg <= 1'b1;
          end
        end

        default: begin
          state_reg    <= IDLE;
          dispense_reg <= 1'b0;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign sum          = sum_reg;
  assign candy_sum    = candy_reg;
  assign dispense     = dispense_reg;
  assign change_pulse = change_reg;
  assign coin_reject  = reject_reg;
  assign vend_denied  = denied_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_candy_vend_ctrl.sv
// -----------------------------------------------------------------------------
// tb_candy_vend_ctrl
// Self-checking bench for candy_vend_ctrl: directed scenarios followed by
// randomized traffic, every output compared each cycle against a behavioural
// model built from credit / candy counts and remaining-cycle counters.
// -----------------------------------------------------------------------------
module tb_candy_vend_ctrl;

  localparam int PRICE           = 3;
  localparam int DISPENSE_CYCLES = 4;
  localparam int MAX_CANDY       = 7;

  // Stimulus vector bits: {reset, refund, vend, coin5, coin2, coin1}
  localparam logic [5:0] C1  = 6'b000001;
  localparam logic [5:0] C2  = 6'b000010;
  localparam logic [5:0] C5  = 6'b000100;
  localparam logic [5:0] VND = 6'b001000;
  localparam logic [5:0] RFD = 6'b010000;
  localparam logic [5:0] RST = 6'b100000;
  localparam logic [5:0] NOP = 6'b000000;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin1, coin2, coin5, vend_req, refund_req;
  logic [3:0] sum;
  logic [2:0] candy_sum;
  logic       dispense, change_pulse, coin_reject, vend_denied, busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int credit;
  int candies;
  int disp_left;
  int refund_left;
  int exp_reject;
  int exp_denied;

  always #5 clk = ~clk;

  candy_vend_ctrl #(
    .PRICE(PRICE),
    .DISPENSE_CYCLES(DISPENSE_CYCLES),
    .MAX_CANDY(MAX_CANDY)
  ) dut (
    .clk(clk),
    .reset(reset),
    .coin1(coin1),
    .coin2(coin2),
    .coin5(coin5),
    .vend_req(vend_req),
    .refund_req(refund_req),
    .sum(sum),
    .candy_sum(candy_sum),
    .dispense(dispense),
    .change_pulse(change_pulse),
    .coin_reject(coin_reject),
    .vend_denied(vend_denied),
    .busy(busy)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge for the given inputs.
  task automatic model_edge(input logic [5:0] in);
    int n, val;
    logic any;
    any = in[0] | in[1] | in[2];
    exp_reject = 0;
    exp_denied = 0;
    if (in[5]) begin
      credit = 0; candies = 0; disp_left = 0; refund_left = 0;
    end else if (disp_left > 0) begin
      exp_reject = any;
      disp_left--;
      if (disp_left == 0) begin
        credit  -= PRICE;
        candies += 1;
      end
    end else if (refund_left > 0) begin
      exp_reject = any;
      credit--;
      refund_left--;
    end else if (in[4]) begin
      exp_reject = any;
      if (credit > 0) refund_left = credit;
    end else if (in[3]) begin
      exp_reject = any;
      if (credit >= PRICE && candies < MAX_CANDY) disp_left = DISPENSE_CYCLES;
      else exp_denied = 1;
    end else begin
      n   = int'(in[0]) + int'(in[1]) + int'(in[2]);
      val = in[2] ? 5 : (in[1] ? 2 : (in[0] ? 1 : 0));
      if (n > 0 && credit + val <= 15) begin
        credit += val;
        n--;
      end
      exp_reject = (n > 0);
    end
  endtask

  // One clock cycle: drive inputs, update model at the edge, check #1 later.
  task automatic step(input logic [5:0] in);
    {reset, refund_req, vend_req, coin5, coin2, coin1} = in;
    @(posedge clk);
    model_edge(in);
    #1;
    check_val("sum",          int'(sum),          credit);
    check_val("candy_sum",    int'(candy_sum),    candies);
    check_val("dispense",     int'(dispense),     int'(disp_left > 0));
    check_val("change_pulse", int'(change_pulse), int'(refund_left > 0));
    check_val("coin_reject",  int'(coin_reject),  exp_reject);
    check_val("vend_denied",  int'(vend_denied),  exp_denied);
    check_val("busy",         int'(busy),         int'(disp_left > 0 || refund_left > 0));
    $display("t=%0t in=%b sum=%0d candy=%0d disp=%b chg=%b rej=%b den=%b busy=%b",
             $time, in, sum, candy_sum, dispense, change_pulse, coin_reject,
             vend_denied, busy);
    {reset, refund_req, vend_req, coin5, coin2, coin1} = NOP;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(NOP);
  endtask

  initial begin
    logic [5:0] in;
    credit = 0; candies = 0; disp_left = 0; refund_left = 0;
    exp_reject = 0; exp_denied = 0;
    {reset, refund_req, vend_req, coin5, coin2, coin1} = RST;
    repeat (2) @(posedge clk);
    #1;

    // Reset state and basic coin accumulation: 2, 3, 8
    step(RST);
    step(C2); step(C1); step(C5);
    // Vend at sum 8 -> 4 dispense cycles, then sum 5 / candy 1
    step(VND); idle(5);
    // Refund down to 0, build sum 2, vend denied
    step(RFD); idle(6);
    step(C2); step(VND); idle(2);
    // Climb to 14, coin2 overflow rejected
    step(C5); step(C5); step(C2); step(C2);
    // Refund, rebuild 9, then coin1+coin5 together -> 14 with reject
    step(RFD); idle(16);
    step(C5); step(C2); step(C2); step(C1 | C5);
    // Refund at sum 5 with vend and coin1 arriving mid-refund
    step(RFD); idle(16);
    step(C5); step(RFD); step(VND | C1); step(C1); idle(5);
    // Fill to MAX_CANDY, then 8th vend denied
    step(RST);
    for (int k = 0; k < 8; k++) begin
      step(C2); step(C1); step(VND); idle(5);
    end
    // Reset in the middle of a dispense
    step(RST); step(C5); step(VND); step(NOP); step(RST); step(NOP);
    // Coins during dispense are rejected
    step(C5); step(VND); step(C2); step(C5 | C1); idle(4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in = NOP;
      in[0] = ($urandom_range(0, 3) == 0);
      in[1] = ($urandom_range(0, 3) == 0);
      in[2] = ($urandom_range(0, 4) == 0);
      in[3] = ($urandom_range(0, 6) == 0);
      in[4] = ($urandom_range(0, 24) == 0);
      in[5] = ($urandom_range(0, 399) == 0);
      step(in);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
